ks_gp_preproc: RTL



---
 rtl/ks_pkg.sv | 20 ++
 rtl/ks_skid_buf.sv | 76 +++++++
 rtl/ks_gp_preproc.sv | 52 +++++
 3 files changed

// File: rtl/ks_pkg.sv
// Shared definitions for the 16-bit Kogge-Stone adder pipeline stages.
package ks_pkg;

  localparam int KS_WIDTH = 16;

  // One pre-processed word handed from the G/P stage to the prefix tree and sum stage.
  typedef struct packed {
    logic [KS_WIDTH-1:0] p;
    logic [KS_WIDTH-1:0] g;
    logic                cin;
  } gp_word_t;

  // Skid buffer occupancy; bit 1 is "main entry valid", bit 0 is "skid entry valid".
  typedef enum logic [1:0] {
    SKID_EMPTY = 2'b00,
    SKID_ONE   = 2'b10,
    SKID_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/ks_skid_buf.sv
// Generic two-entry valid/ready skid buffer; every output comes straight from a flop.
module ks_skid_buf
  import ks_pkg::*;
#(
  parameter int DATA_W = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  skid_state_e       state_q, state_d;
  logic [DATA_W-1:0] mData_q, mData_d;
  logic [DATA_W-1:0] sData_q, sData_d;
  logic              accept;
  logic              deliver;

  // The state encoding doubles as the registered handshake outputs.
  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];
  assign out_data  = mData_q;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;

  // Next occupancy and entry contents; the main entry only changes when it is empty or being consumed.
  always_comb begin
    state_d = state_q;
    mData_d = mData_q;
    sData_d = sData_q;
    case (state_q)
      SKID_EMPTY: begin
        if (accept) begin
          mData_d = in_data;
          state_d = SKID_ONE;
        end
      end
      SKID_ONE: begin
        if (accept && deliver) begin
          mData_d = in_data;
        end else if (accept) begin
          sData_d = in_data;
          state_d = SKID_FULL;
        end else if (deliver) begin
          state_d = SKID_EMPTY;
        end
      end
      SKID_FULL: begin
        if (deliver) begin
          mData_d = sData_q;
          state_d = SKID_ONE;
        end
      end
      default: state_d = SKID_EMPTY;
    endcase
  end

  // State and data registers; reset empties both entries and clears the visible data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      mData_q <= '0;
      sData_q <= '0;
    end else begin
      state_q <= state_d;
      mData_q <= mData_d;
      sData_q <= sData_d;
    end
  end

endmodule

// File: rtl/ks_gp_preproc.sv
// Kogge-Stone pre-processing stage: per-bit propagate/generate with carry-in folded into bit 0.
module ks_gp_preproc
  import ks_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_p,
  output logic [WIDTH-1:0] out_g,
  output logic             out_cin
);

  localparam int WordW = 2 * WIDTH + 1;

  logic [WIDTH-1:0] pComb;
  logic [WIDTH-1:0] gComb;
  logic [WordW-1:0] inWord;
  logic [WordW-1:0] outWord;

  // Bit 0 absorbs the carry-in so the prefix tree never needs a separate cin input.
  always_comb begin
    pComb    = in_a ^ in_b;
    gComb    = in_a & in_b;
    gComb[0] = (in_a[0] & in_b[0]) | (pComb[0] & in_cin);
  end

  assign inWord = {pComb, gComb, in_cin};

  ks_skid_buf #(
    .DATA_W(WordW)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (inWord),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (outWord)
  );

  assign {out_p, out_g, out_cin} = outWord;

endmodule
